multi_edge_sync: RTL
====================

// Module: multi_edge_sync
// PURPOSE
//  N-channel asynchronous event synchroniser; generalises the single-channel pulse sync to a parametrised block.
//  Brings async inputs (keys, switches, slow divided clocks) into the main_clock domain through a configurable sync chain.
//  Each channel has a glitch filter, edge detection with a selectable mode, and a one-cycle pulse output.
//  Each channel also has a sticky pending/ack handshake, an overflow flag and a saturating event counter.
// PARAMETERS
//  N            default 4   number of independent channels (1..32)
//  SYNC_STAGES  default 2   synchroniser flops per channel (>=2)
//  FILTER_LEN   default 4   consecutive stable cycles required to accept a new level (>=1; 1 = no filtering)
//  EDGE_MODE    default 0   0 rising, 1 falling, 2 both; 3 is treated as rising
//  CNT_W        default 8   width of each per-channel event counter
// PORTS
//  main_clock   in   1        system clock, all logic on posedge
//  reset_n      in   1        synchronous, active-low reset
//  async_in     in   N        asynchronous inputs, one per channel
//  ack_i        in   N        per-channel acknowledge, clears pending/overflow
//  clear_cnt_i  in   1        synchronous clear of all event counters
//  level_o      out  N        filtered, synchronised level
//  pulse_o      out  N        one-cycle event pulse (edge matching EDGE_MODE)
//  pending_o    out  N        sticky event flag, held until ack
//  overflow_o   out  N        sticky: event arrived while pending was set and not acked
//  count_o      out  N*CNT_W  per-channel event counts; channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): every flop clears to 0, including sync chain, filter counters and level.
//   All outputs read 0 in the cycle after reset.
//  Sync: async_in[i] passes through SYNC_STAGES flops; sync_q is the last stage. There is no logic between stages.
//  Filter: per-channel counter fcnt, width clog2(FILTER_LEN)+1.
//   sync_q==level_q: fcnt<=0.
//   sync_q!=level_q and fcnt<FILTER_LEN-1: fcnt<=fcnt+1.
//   sync_q!=level_q and fcnt==FILTER_LEN-1: level_q<=sync_q, fcnt<=0 (the "accept" event).
//   A mismatch shorter than FILTER_LEN cycles is discarded with no trace.
//  Edge: pulse_o is registered and asserted in the same cycle level_o takes its new value, for exactly 1 cycle.
//   The accepted transition must match EDGE_MODE.
//  Latency: a clean input step sampled at edge k gives level_o/pulse_o at edge k+SYNC_STAGES+FILTER_LEN-1 (visible after it).
//  Handshake, per channel, evaluated each cycle from the registered pulse:
//   pulse & !pending          -> pending<=1
//   pulse & pending & !ack    -> overflow<=1, pending stays 1
//   pulse & ack               -> pending stays 1, overflow<=0 (new event wins, ack consumed the old one)
//   !pulse & ack              -> pending<=0, overflow<=0
//   An ack with nothing pending is a no-op.
//  Counter: +1 per pulse, saturates at 2^CNT_W-1 (no wrap).
//   clear_cnt_i has priority over a same-cycle pulse; the result is 0 and that event is not counted.
//  Reset mid-operation: in-flight filter progress is lost.
//   An input held high across reset re-enters as a rising edge after the full latency (level starts at 0).
//  Channels are fully independent; simultaneous events on all channels are all captured.
// STRUCTURE
//  Package edge_sync_pkg: EDGE_RISE/EDGE_FALL/EDGE_BOTH localparams and a clog2 function.
//  Sub-module edge_sync_chan: one channel (sync chain, filter, edge, handshake, counter).
//   The top level is a generate loop over N plus count_o packing.
//  Mark sync-chain flops with the synthesis ASYNC_REG attribute; only sync stage 1 sees async_in.
// TESTING
//  1. Reset: hold reset_n=0 4 cycles with async_in=4'hF, then release.
//     -> pulse_o[all] fires once at cycle SYNC_STAGES+FILTER_LEN-1 after release; count_o=1 per channel.
//  2. Glitch: defaults, async_in[0] high for 3 cycles then low -> no pulse, level_o[0]=0, count unchanged.
//     Held 10 cycles -> one pulse 5 cycles after first sample.
//  3. Handshake: 2 rising events on ch1 with no ack -> pending_o[1]=1, overflow_o[1]=1.
//     ack_i[1] for 1 cycle -> both 0.
//     Pulse coincident with ack -> pending=1, overflow=0.
//  4. Saturation: CNT_W=3, 9 events on ch2 -> count reads 7.
//     clear_cnt_i coincident with an event -> 0.
//  5. EDGE_MODE=2: toggle ch3 four times (each held 8 cycles) -> 4 pulses, count=4.
//     EDGE_MODE=1 -> 2 pulses, on falls only.
//  6. Mid-run reset: assert reset_n=0 during ch0 filter count -> all outputs 0 next cycle, no spurious pulse after release.

Source files
------------

// File: rtl/multi_edge_sync_pkg.sv
// Shared constants and helpers for the multi-channel edge synchroniser.
package edge_sync_pkg;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/multi_edge_sync_chan.sv
// One channel: sync chain, glitch filter, edge pulse,
// sticky pending/overflow handshake and saturating event counter.
module edge_sync_chan
   import edge_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int EDGE_MODE   = EDGE_RISE,
   parameter int CNT_W       = 8
) (
   input  logic             main_clock,
   input  logic             reset_n,
   input  logic             async_in,
   input  logic             ack_i,
   input  logic             clear_cnt_i,
   output logic             level_o,
   output logic             pulse_o,
   output logic             pending_o,
   output logic             overflow_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int FW = clog2(FILTER_LEN) + 1;
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_STAGES-1:0] sync_r;

   logic             sync_q;
   logic [FW-1:0]    fcnt;
   logic             level_q;
   logic             pulse_q;
   logic             pending_q;
   logic             overflow_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             edge_ok;

   assign sync_q = sync_r[SYNC_STAGES-1];
   assign accept = (sync_q != level_q) && (fcnt == FMAX);

   // sync_q is the level about to be accepted
   always_comb begin
      edge_ok = sync_q;
      case (EDGE_MODE)
         EDGE_FALL: edge_ok = !sync_q;
         EDGE_BOTH: edge_ok = 1'b1;
         default:   edge_ok = sync_q;
      endcase
   end

   always_ff @(posedge main_clock) begin
      if (!reset_n) begin
         sync_r  <= '0;
         fcnt    <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_r  <= {sync_r[SYNC_STAGES-2:0], async_in};
         pulse_q <= accept && edge_ok;
         if (sync_q == level_q) begin
            fcnt <= '0;
         end else if (accept) begin
            level_q <= sync_q;
            fcnt    <= '0;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   always_ff @(posedge main_clock) begin
      if (!reset_n) begin
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else if (pulse_q) begin
         pending_q <= 1'b1;
         if (ack_i)
            overflow_q <= 1'b0;
         else if (pending_q)
            overflow_q <= 1'b1;
      end else if (ack_i) begin
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge main_clock) begin
      if (!reset_n)
         cnt_q <= '0;
      else if (clear_cnt_i)
         cnt_q <= '0;
      else if (pulse_q && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign level_o    = level_q;
   assign pulse_o    = pulse_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;
   assign count_o    = cnt_q;

endmodule

// File: rtl/multi_edge_sync.sv
// N-channel asynchronous event synchroniser; one
// independent edge_sync_chan per input bit.
module multi_edge_sync
   import edge_sync_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int EDGE_MODE   = 0,
   parameter int CNT_W       = 8
) (
   input  logic               main_clock,
   input  logic               reset_n,
   input  logic [N-1:0]       async_in,
   input  logic [N-1:0]       ack_i,
   input  logic               clear_cnt_i,
   output logic [N-1:0]       level_o,
   output logic [N-1:0]       pulse_o,
   output logic [N-1:0]       pending_o,
   output logic [N-1:0]       overflow_o,
   output logic [N*CNT_W-1:0] count_o
);

   // mode 3 folds onto rising
   localparam int MODE = (EDGE_MODE == 3) ? EDGE_RISE : EDGE_MODE;

   for (genvar i = 0; i < N; i++) begin : g_chan
      edge_sync_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .EDGE_MODE   (MODE),
         .CNT_W       (CNT_W)
      ) u_chan (
         .main_clock  (main_clock),
         .reset_n     (reset_n),
         .async_in    (async_in[i]),
         .ack_i       (ack_i[i]),
         .clear_cnt_i (clear_cnt_i),
         .level_o     (level_o[i]),
         .pulse_o     (pulse_o[i]),
         .pending_o   (pending_o[i]),
         .overflow_o  (overflow_o[i]),
         .count_o     (count_o[i*CNT_W +: CNT_W])
      );
   end

endmodule
